// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift path: default widths, op codes and
// the shift sequencer state encoding.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHW_DEFAULT  = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves data by a small amount (1 or 4)
// in the direction and fill mode selected by op.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] data_i,
  input  op_e             op_i,
  input  logic [2:0]      amount_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << amount_i;
      OP_SRL:  data_o = data_i >> amount_i;
      OP_SRA:  data_o = $signed(data_i) >>> amount_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift sequencer (IDLE -> SHIFT -> DONE) with valid/ready on both sides.
// Define ALU_SHIFT_FAST_STEP_EN to step by 4 bits while at least 4 remain.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = SHW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] step_data;
  logic [2:0]      step_amt;
  logic            unused_rs2_hi;

  // Upper shift-amount bits are architecturally ignored.
  assign unused_rs2_hi = ^rs2[XLEN-1:SHW];

`ifdef ALU_SHIFT_FAST_STEP_EN
  assign step_amt = (cnt_q >= SHW'(4)) ? 3'd4 : 3'd1;
`else
  assign step_amt = 3'd1;
`endif

  alu_shift_step #(.XLEN(XLEN)) u_step (
    .data_i   (data_q),
    .op_i     (op_q),
    .amount_i (step_amt),
    .data_o   (step_data)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  // rd is driven only from flops and forced to zero outside DONE.
  assign rd        = (state_q == S_DONE) ? data_q : '0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op_e'(op);
          data_d = rs1;
          cnt_d  = rs2[SHW-1:0];
          if ((rs2[SHW-1:0] == '0) || (op_e'(op) == OP_RSV)) state_d = S_DONE;
          else                                               state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - SHW'(step_amt);
        if (cnt_q == SHW'(step_amt)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed test-plan vectors, random
// operations against an arithmetic reference model, backpressure and reset abort.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int MAX_WAIT = 100;

  alu_shift_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    int n;
    n = int'(b % 32);
    case (o)
      2'd0:    return a << n;
      2'd1:    return a >> n;
      2'd2:    return 32'($signed(a) >>> n);
      default: return a;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    int n;
    n = int'(b % 32);
    if (o == 2'd3 || n == 0) return 1;
`ifdef ALU_SHIFT_FAST_STEP_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits for out_valid with out_ready low, records rd
  // and latency (accepting edge counts as 1), then completes the handshake.
  task automatic run_txn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output bit timeout);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    timeout = 1'b0;
    while (!out_valid && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    r = rd;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || rd !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b rd=%h busy=%b in_ready=%b, required 0 0 0 1",
               out_valid, rd, busy, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [31:0] t_rs1 [7] = '{32'h1, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000,
                               32'h12345678, 32'h12345678};
    logic [31:0] t_rs2 [7] = '{32'd1, 32'd3, 32'd33, 32'd31, 32'd31, 32'd0, 32'd5};
    logic [31:0] t_exp [7] = '{32'h2, 32'hFFFFFFF8, 32'h2, 32'hFFFFFFFF, 32'h1,
                               32'h12345678, 32'h12345678};
    logic [31:0] r;
    int lat;
    bit to;
    for (int i = 0; i < 7; i++) begin
      run_txn(t_op[i], t_rs1[i], t_rs2[i], r, lat, to);
      n_checks++;
      if (to || r !== t_exp[i]) begin
        n_fail++;
        $display("FAIL directed_rd[%0d]: got %h timeout=%0d, required %h", i, r, to, t_exp[i]);
      end
      n_checks++;
      if (lat != model_lat(t_op[i], t_rs2[i])) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat,
                 model_lat(t_op[i], t_rs2[i]));
      end
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || rd !== 32'h0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_after_handshake[%0d]: busy=%b out_valid=%b rd=%h in_ready=%b, required 0 0 0 1",
                 i, busy, out_valid, rd, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, r;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      run_txn(o, a, b, r, lat, to);
      n_checks++;
      if (to || r !== model_rd(o, a, b)) begin
        n_fail++;
        $display("FAIL random_rd[%0d] op=%0d rs1=%h rs2=%h: got %h, required %h",
                 i, o, a, b, r, model_rd(o, a, b));
      end
      n_checks++;
      if (lat != model_lat(o, b)) begin
        n_fail++;
        $display("FAIL random_latency[%0d] op=%0d rs2=%h: got %0d, required %0d",
                 i, o, b, lat, model_lat(o, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp;
    int waited;
    int extra;
    a = $urandom;
    b = 32'd7;
    exp = model_rd(2'd1, a, b);
    op = 2'd1; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < MAX_WAIT) begin
      tick();
      waited++;
    end
    for (int c = 0; c < 5; c++) begin
      // Stray requests while the result is held must be ignored.
      in_valid = c[0];
      op = 2'd0; rs1 = $urandom; rs2 = 32'd2;
      n_checks++;
      if (out_valid !== 1'b1 || rd !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b rd=%h in_ready=%b busy=%b, required 1 %h 0 1",
                 c, out_valid, rd, in_ready, busy, exp);
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || rd !== exp) begin
      n_fail++;
      $display("FAIL backpressure_before_release: out_valid=%b rd=%h, required 1 %h",
               out_valid, rd, exp);
    end
    out_ready = 1'b1;
    tick();
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (extra != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_single_transfer: extra out_valid cycles=%0d busy=%b, required 0 0",
               extra, busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    int lat;
    bit to;
    int seen;
    op = 2'd0; rs1 = 32'h0000_0003; rs2 = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_busy: busy=%b out_valid=%b, required 1 0", busy, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || rd !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: out_valid=%b rd=%h in_ready=%b busy=%b, required 0 0 1 0",
               out_valid, rd, in_ready, busy);
    end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midop_no_result: out_valid cycles after abort=%0d, required 0", seen);
    end
    run_txn(2'd2, 32'hF000_0000, 32'd4, r, lat, to);
    n_checks++;
    if (to || r !== 32'hFF00_0000 || lat != model_lat(2'd2, 32'd4)) begin
      n_fail++;
      $display("FAIL midop_fresh: rd=%h lat=%0d timeout=%0d, required ff000000 %0d 0",
               r, lat, to, model_lat(2'd2, 32'd4));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
